// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: function codes, FSM states and default sizes.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 6;
    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned FXN_W         = 3;

    typedef enum logic [FXN_W-1:0] {
        FXN_PASS_A = 3'b000,
        FXN_PASS_B = 3'b001,
        FXN_NEG_A  = 3'b010,
        FXN_NEG_B  = 3'b011,
        FXN_SLT    = 3'b100,
        FXN_XNOR   = 3'b101,
        FXN_ADD    = 3'b110,
        FXN_SUB    = 3'b111
    } fxn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-load channel of the ALU sequencer: valid/ready write of {fxn, operand}.
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             load_valid;
    logic             load_ready;
    logic [FXN_W-1:0] load_fxn;
    logic [WIDTH-1:0] load_operand;

    modport master (output load_valid, load_fxn, load_operand, input load_ready);
    modport slave  (input load_valid, load_fxn, load_operand, output load_ready);
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational two's-complement ALU: x_c = fxn(a, b), modulo 2^WIDTH.
module alu_sequencer_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  fxn_e             fxn,
    output logic [WIDTH-1:0] x_c
);

    always_comb begin
        x_c = '0;
        case (fxn)
            FXN_PASS_A: x_c = a;
            FXN_PASS_B: x_c = b;
            FXN_NEG_A:  x_c = WIDTH'(-a);
            FXN_NEG_B:  x_c = WIDTH'(-b);
            FXN_SLT:    x_c = ($signed(a) < $signed(b)) ? '1 : '0;
            FXN_XNOR:   x_c = ~(a ^ b);
            FXN_ADD:    x_c = WIDTH'(a + b);
            FXN_SUB:    x_c = WIDTH'(a - b);
            default:    x_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Program buffer plus accumulator sequencer: executes loaded entries one per cycle
// from a seeded accumulator and reports result, sticky signed overflow and done.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_sequencer_if.slave         lif,
    input  logic                   clear,
    input  logic                   start,
    input  logic [WIDTH-1:0]       init_acc,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned CW  = IW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    state_e           state;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] acc;
    fxn_e             mem_fxn [DEPTH];
    logic [WIDTH-1:0] mem_op  [DEPTH];

    fxn_e             cur_fxn;
    logic [WIDTH-1:0] cur_op;
    logic [WIDTH-1:0] alu_x;
    logic             step_ovf;
    logic             start_go;
    logic             load_go;

    assign cur_fxn  = mem_fxn[idx[IW-1:0]];
    assign cur_op   = mem_op[idx[IW-1:0]];
    assign result   = acc;

    // start wins over clear and load; an empty-buffer start is simply dropped
    assign start_go = start && (state == ST_IDLE) && (count != '0);
    assign load_go  = lif.load_valid && lif.load_ready && (state == ST_IDLE)
                      && !start_go && !clear;

    alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (acc),
        .b   (cur_op),
        .fxn (cur_fxn),
        .x_c (alu_x)
    );

    // Signed overflow of the current add/subtract step
    always_comb begin
        step_ovf = 1'b0;
        case (cur_fxn)
            FXN_ADD: step_ovf = (acc[MSB] == cur_op[MSB]) && (alu_x[MSB] != acc[MSB]);
            FXN_SUB: step_ovf = (acc[MSB] != cur_op[MSB]) && (alu_x[MSB] != acc[MSB]);
            default: step_ovf = 1'b0;
        endcase
    end

    // Buffer storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (load_go) begin
            mem_fxn[count[IW-1:0]] <= fxn_e'(lif.load_fxn);
            mem_op[count[IW-1:0]]  <= lif.load_operand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            count          <= '0;
            idx            <= '0;
            acc            <= '0;
            ovf            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            lif.load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        acc            <= init_acc;
                        idx            <= '0;
                        ovf            <= 1'b0;
                        busy           <= 1'b1;
                        lif.load_ready <= 1'b0;
                        state          <= ST_RUN;
                    end else if (clear) begin
                        count          <= '0;
                        lif.load_ready <= 1'b1;
                    end else if (load_go) begin
                        count          <= count + CW'(1);
                        lif.load_ready <= (count != CW'(DEPTH - 1));
                    end
                end
                ST_RUN: begin
                    acc <= alu_x;
                    ovf <= ovf | step_ovf;
                    idx <= idx + CW'(1);
                    if (idx == count - CW'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // done pulses as the sequencer drops back to IDLE
                    state          <= ST_IDLE;
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    lif.load_ready <= (count < CW'(DEPTH));
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer against an integer reference model.
module tb_alu_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int          MASK  = (1 << WIDTH) - 1;
    localparam int          SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int          SMIN  = -(1 << (WIDTH - 1));

    typedef struct {
        int res;
        bit ov;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] init_acc = '0;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;

    alu_sequencer_if #(.WIDTH(WIDTH)) lif ();

    alu_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lif      (lif.slave),
        .clear    (clear),
        .start    (start),
        .init_acc (init_acc),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .count    (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   prog_f[$];
    int   prog_b[$];
    int   m_count = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int sx(int v);
        return (v > SMAX) ? v - (1 << WIDTH) : v;
    endfunction

    // Reference: run the loaded program with plain signed integer arithmetic
    function automatic void model_run(input int init, output int res, output bit ov);
        int a;
        int r;
        int s;
        a  = init & MASK;
        ov = 1'b0;
        for (int i = 0; i < m_count; i++) begin
            case (prog_f[i])
                0: r = a;
                1: r = prog_b[i];
                2: r = -a;
                3: r = -prog_b[i];
                4: r = (sx(a) < sx(prog_b[i])) ? MASK : 0;
                5: r = ~(a ^ prog_b[i]);
                6: begin
                    s = sx(a) + sx(prog_b[i]);
                    if (s > SMAX || s < SMIN) ov = 1'b1;
                    r = s;
                end
                default: begin
                    s = sx(a) - sx(prog_b[i]);
                    if (s > SMAX || s < SMIN) ov = 1'b1;
                    r = s;
                end
            endcase
            a = r & MASK;
        end
        res = a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input int f, input int b);
        lif.load_valid   = 1'b1;
        lif.load_fxn     = 3'(f);
        lif.load_operand = WIDTH'(b);
        check("load_ready", 32'(lif.load_ready), 32'(m_count < DEPTH));
        if (m_count < DEPTH) begin
            prog_f.push_back(f & 7);
            prog_b.push_back(b & MASK);
            m_count++;
        end
        tick();
        lif.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_count = 0;
        prog_f.delete();
        prog_b.delete();
    endtask

    task automatic start_run(input int init);
        int res;
        bit ov;
        init_acc = WIDTH'(init);
        start    = 1'b1;
        if (m_count > 0) begin
            model_run(init, res, ov);
            sb.push_back('{res, ov, cyc + m_count + 2});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check("done timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        tick();
    endtask

    // Monitor: every done pulse is matched against the oldest expected run
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("done latency", 32'(cyc), 32'(e.cyc));
                check("busy with done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        lif.load_valid   = 1'b0;
        lif.load_fxn     = '0;
        lif.load_operand = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst load_ready", 32'(lif.load_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst count", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Mixed add/sub/xnor program
        load1(6, 5); load1(7, 3); load1(5, 6'b110011);
        start_run(10);
        wait_done();
        check("s1 result", 32'(result), 32'd0);
        check("s1 ovf", 32'(ovf), 32'd0);

        // Add overflow, then ovf cleared by the next run
        do_clear();
        load1(6, 1);
        start_run(31);
        wait_done();
        check("s2 result", 32'(result), 32'd32);
        check("s2 ovf", 32'(ovf), 32'd1);
        start_run(0);
        wait_done();
        check("s2b ovf", 32'(ovf), 32'd0);
        check("s2b result", 32'(result), 32'd1);

        // Signed compare then negate
        do_clear();
        load1(4, 6'b111110); load1(3, 1);
        start_run(3);
        wait_done();
        check("s3 result", 32'(result), 32'd63);

        // Nine back-to-back loads: the ninth is refused and never executed
        do_clear();
        for (int i = 0; i < 9; i++) load1(6, i + 1);
        check("full count", 32'(count), 32'(DEPTH));
        check("full load_ready", 32'(lif.load_ready), 32'd0);
        start_run(0);
        wait_done();
        check("full result", 32'(result), 32'd36);

        // Clear beats a same-cycle load
        lif.load_valid = 1'b1;
        lif.load_fxn   = 3'd1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        lif.load_valid = 1'b0;
        m_count = 0; prog_f.delete(); prog_b.delete();
        check("clear prio count", 32'(count), 32'd0);

        // Empty start is ignored
        start_run(5);
        check("empty start busy", 32'(busy), 32'd0);
        repeat (4) tick();
        check("empty start busy2", 32'(busy), 32'd0);

        // Start and load during RUN are ignored
        load1(6, 2); load1(7, 1); load1(6, 4); load1(1, 9);
        start_run(7);
        init_acc = WIDTH'(33);
        start = 1'b1;
        lif.load_valid = 1'b1;
        check("run load_ready", 32'(lif.load_ready), 32'd0);
        tick();
        start = 1'b0;
        lif.load_valid = 1'b0;
        check("run busy", 32'(busy), 32'd1);
        wait_done();
        check("run count", 32'(count), 32'(m_count));

        // Reset during the second RUN step
        do_clear();
        load1(6, 1); load1(6, 2); load1(6, 3); load1(6, 4);
        start_run(1);
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_count = 0; prog_f.delete(); prog_b.delete();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst count", 32'(count), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("midrst busy2", 32'(busy), 32'd0);
        check("midrst load_ready", 32'(lif.load_ready), 32'd1);

        // Randomized programs, sometimes reusing or extending the buffer
        for (int it = 0; it < 30; it++) begin
            int n;
            if ($urandom_range(0, 3) != 0 || m_count == 0) do_clear();
            n = $urandom_range(0, DEPTH);
            if (m_count == 0 && n == 0) n = 1;
            for (int k = 0; k < n; k++)
                load1(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)));
            start_run(int'($urandom_range(0, MASK)));
            wait_done();
            check("rand count", 32'(count), 32'(m_count));
        end

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning program buffer entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 6, meaning operand/accumulator width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_valid  input  1  program-entry write request.
REQ-006 The block SHALL have port load_ready  output  1  buffer can accept an entry this cycle.
REQ-007 The block SHALL have port load_fxn  input  3  ALU function code of the entry.
REQ-008 The block SHALL have port load_operand  input  WIDTH  B operand of the entry.
REQ-009 The block SHALL have port clear  input  1  empty the program buffer (accepted only in IDLE).
REQ-010 The block SHALL have port start  input  1  single-cycle run request.
REQ-011 The block SHALL have port init_acc  input  WIDTH  accumulator seed, sampled on an accepted start.
REQ-012 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-013 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port result  output  WIDTH  accumulator value, stable outside RUN.
REQ-015 The block SHALL have port ovf  output  1  sticky signed overflow of any add/subtract step in the last run.
REQ-016 The block SHALL have port count  output  log2(DEPTH)+1  number of loaded entries.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DONE.
REQ-018 In IDLE, the block SHALL assert load_ready = (count < DEPTH), and a load_valid&&load_ready cycle SHALL write {fxn,operand} at index count and increment count.
REQ-019 Loads while full, or in RUN or DONE, SHALL be ignored with load_ready=0.
REQ-020 In IDLE, clear SHALL set count=0; clear outside IDLE SHALL be ignored, and clear SHALL have priority over a same-cycle load.
REQ-021 A start in IDLE with count>0 SHALL set acc=init_acc, idx=0 and ovf=0, then go to RUN; a start with count=0 or while busy SHALL be ignored; start SHALL have priority over a same-cycle load or clear.
REQ-022 Each RUN cycle SHALL compute acc <= ALU(A=acc, B=operand[idx], fxn[idx]) and increment idx, giving one entry per cycle.
REQ-023 After the entry at idx=count-1 executes, the block SHALL enter DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Latency from the start-sampling edge to done high SHALL be count+1 cycles.
REQ-025 ALU functions SHALL be: 000 A; 001 B; 010 -A; 011 -B; 100 all-ones if signed A<B, else zero; 101 ~(A^B); 110 A+B; 111 A-B; all arithmetic is two's complement modulo 2^WIDTH.
REQ-026 ovf SHALL set when a 110 step has same-sign operands and a result of a different sign, or a 111 step has different-sign operands and a result sign differing from A; ovf SHALL hold until the next accepted start.
REQ-027 result SHALL equal acc; the program buffer and count SHALL be retained after a run so the same program can be restarted.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, count=0, acc/result=0, ovf=0, done=0 and busy=0, including in the middle of a run; load_ready SHALL be 1 after reset.
REQ-029 Buffer contents SHALL NOT require reset, and entries at or above count SHALL never be executed.

Structure
REQ-030 Package alu_pkg SHALL hold the fxn code constants (FXN_PASS_A..FXN_SUB), the state encoding and the WIDTH default.
REQ-031 The block SHALL instantiate exactly one combinational ALU sub-module (A, B, fxn -> X); the buffer, FSM and overflow logic SHALL be local.

Verification
REQ-032 Scenario: init_acc=001010, program {110,000101},{111,000011},{101,110011}, start -> done 4 cycles later, result=000000, ovf=0.
REQ-033 Scenario: init_acc=011111, program {110,000001} -> result=100000, ovf=1; restart with init_acc=000000 -> ovf=0.
REQ-034 Scenario: init_acc=000011, program {100,111110},{011,000001} -> result=111111 (3<-2 is false, then -1).
REQ-035 Scenario: nine consecutive loads with load_valid held -> load_ready=0 on the ninth, count=8, and the ninth entry is never executed.
REQ-036 Scenario: start with count=0 -> no busy, no done; start during RUN -> ignored and the run completes unchanged.
REQ-037 Scenario: rst_n low for 1 cycle during the second RUN step -> busy=0, count=0, result=000000 and done never pulses.
